// File: rtl/cam_cfg_pkg.sv
// Shared definitions for the camera configuration sequencer.
// Contents: sequencer state encoding, ROM sentinel words and ROM address width.
package cam_cfg_pkg;

    localparam int unsigned ROM_ADDR_W = 8;

    // ROM words with special meaning; every other word is a {register, value} write.
    localparam logic [15:0] CFG_DELAY = 16'hFF_F0;
    localparam logic [15:0] CFG_END   = 16'hFF_FF;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StSend,
        StWait,
        StDelay,
        StDone
    } cfg_state_e;

endpackage

// File: rtl/cfg_delay_timer.sv
// Loadable down-counter with a terminal-count flag.
// Ports:
//   i_clk, i_rst    - clock, asynchronous active-high reset (count clears to 0)
//   i_load          - load i_load_val (takes priority over decrement)
//   i_load_val      - value to load
//   i_dec           - decrement by one; holds at 0
//   o_zero          - count is 0
module cfg_delay_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - ONE;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Camera configuration sequencer: walks the config ROM from address 0 and issues each
// {register, value} word as one SCCB write. 16'hFF_F0 inserts a DELAY_MS pause,
// 16'hFF_FF ends the sequence. At most 256 entries are processed.
// Ports:
//   i_clk, i_rst        - clock, asynchronous active-high reset
//   i_start             - start pulse, honoured only when idle
//   o_busy, o_done      - sequence running / sequence finished (level until next start)
//   o_rom_addr          - config ROM address (ROM has 1-cycle read latency)
//   i_rom_data          - ROM word: [15:8] register, [7:0] value
//   o_sccb_valid/_reg/_data, i_sccb_ready - write request handshake to SCCB master
//   i_sccb_done         - pulse when the bus write has completed
module cam_cfg_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 25_000_000,
    parameter int unsigned DELAY_MS = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ROM_ADDR_W-1:0] o_rom_addr,
    input  logic [15:0]           i_rom_data,
    output logic                  o_sccb_valid,
    output logic [7:0]            o_sccb_reg,
    output logic [7:0]            o_sccb_data,
    input  logic                  i_sccb_ready,
    input  logic                  i_sccb_done
);

    localparam int unsigned DELAY_CYCLES = CLK_FREQ / 1000 * DELAY_MS;
    localparam int unsigned CNT_W_RAW    = $clog2(DELAY_CYCLES + 1);
    localparam int unsigned CNT_W        = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    // Counter runs N-1 .. 0, so DELAY lasts exactly DELAY_CYCLES cycles.
    localparam logic [CNT_W-1:0] DELAY_LOAD =
        CNT_W'((DELAY_CYCLES == 0) ? 0 : DELAY_CYCLES - 1);

    localparam logic [ROM_ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ROM_ADDR_W-1:0] ADDR_ONE  = ROM_ADDR_W'(1);

    cfg_state_e            r_state, w_state_next;
    logic [ROM_ADDR_W-1:0] r_rom_addr, w_rom_addr_next;
    logic                  r_busy, w_busy_next;
    logic                  r_done, w_done_next;
    logic                  r_sccb_valid, w_sccb_valid_next;
    logic [7:0]            r_sccb_reg, w_sccb_reg_next;
    logic [7:0]            r_sccb_data, w_sccb_data_next;
    logic                  w_tmr_load;
    logic                  w_tmr_dec;
    logic                  w_tmr_zero;
    logic                  w_advance;

    cfg_delay_timer #(
        .WIDTH (CNT_W)
    ) u_delay_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_tmr_load),
        .i_load_val (DELAY_LOAD),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_rom_addr   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sccb_valid <= 1'b0;
            r_sccb_reg   <= '0;
            r_sccb_data  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_rom_addr   <= w_rom_addr_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
            r_sccb_valid <= w_sccb_valid_next;
            r_sccb_reg   <= w_sccb_reg_next;
            r_sccb_data  <= w_sccb_data_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_rom_addr_next   = r_rom_addr;
        w_busy_next       = r_busy;
        w_done_next       = r_done;
        w_sccb_valid_next = r_sccb_valid;
        w_sccb_reg_next   = r_sccb_reg;
        w_sccb_data_next  = r_sccb_data;
        w_tmr_load        = 1'b0;
        w_tmr_dec         = 1'b0;
        w_advance         = 1'b0;

        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next    = StFetch;
                    w_rom_addr_next = '0;
                    w_busy_next     = 1'b1;
                    w_done_next     = 1'b0;
                end
            end
            StFetch: begin
                w_state_next = StDecode;
            end
            StDecode: begin
                if (i_rom_data == CFG_END) begin
                    w_state_next = StDone;
                end else if (i_rom_data == CFG_DELAY) begin
                    w_tmr_load   = 1'b1;
                    w_state_next = StDelay;
                end else begin
                    w_sccb_reg_next   = i_rom_data[15:8];
                    w_sccb_data_next  = i_rom_data[7:0];
                    w_sccb_valid_next = 1'b1;
                    w_state_next      = StSend;
                end
            end
            StSend: begin
                // valid is always high here, so ready alone marks the transfer
                if (i_sccb_ready) begin
                    w_sccb_valid_next = 1'b0;
                    w_state_next      = StWait;
                end
            end
            StWait: begin
                w_advance = i_sccb_done;
            end
            StDelay: begin
                if (w_tmr_zero) begin
                    w_advance = 1'b1;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            StDone: begin
                w_busy_next  = 1'b0;
                w_done_next  = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        // Moving past the last ROM address ends the sequence instead of wrapping.
        if (w_advance) begin
            if (r_rom_addr == ADDR_LAST) begin
                w_state_next = StDone;
            end else begin
                w_rom_addr_next = r_rom_addr + ADDR_ONE;
                w_state_next    = StFetch;
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_rom_addr   = r_rom_addr;
    assign o_sccb_valid = r_sccb_valid;
    assign o_sccb_reg   = r_sccb_reg;
    assign o_sccb_data  = r_sccb_data;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Directed bench for cam_cfg_sequencer with a behavioural ROM and SCCB master.
module tb_cam_cfg_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sccb_valid;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_data;
    logic        sccb_ready;
    logic        sccb_done;

    cam_cfg_sequencer #(
        .CLK_FREQ (100_000),
        .DELAY_MS (1)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .o_busy       (busy),
        .o_done       (done),
        .o_rom_addr   (rom_addr),
        .i_rom_data   (rom_data),
        .o_sccb_valid (sccb_valid),
        .o_sccb_reg   (sccb_reg),
        .o_sccb_data  (sccb_data),
        .i_sccb_ready (sccb_ready),
        .i_sccb_done  (sccb_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Config ROM, one cycle read latency
    logic [15:0] rom [256];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // SCCB master: logs each transfer and pulses done done_lat cycles later
    int         n_xfer = 0;
    logic [7:0] xfer_reg  [$];
    logic [7:0] xfer_data [$];
    int         done_lat = 20;
    int         done_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt = 0;
            sccb_done <= 1'b0;
        end else begin
            sccb_done <= 1'b0;
            if (sccb_valid && sccb_ready) begin
                n_xfer++;
                xfer_reg.push_back(sccb_reg);
                xfer_data.push_back(sccb_data);
                done_cnt = done_lat;
            end else if (done_cnt == 1) begin
                done_cnt = 0;
                sccb_done <= 1'b1;
            end else if (done_cnt > 1) begin
                done_cnt--;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic rom_fill(input logic [15:0] w);
        for (int i = 0; i < 256; i++) rom[i] = w;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget && !done; i++) @(negedge clk);
        check_eq(tag, done, 1);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        for (int i = 0; i < budget && !sccb_valid; i++) @(negedge clk);
        check_eq(tag, sccb_valid, 1);
    endtask

    int base;
    int t1, t2, tv, viol;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        sccb_ready = 1'b1;
        rom_fill(16'hFFFF);

        // Reset values
        #12;
        check_eq("rst_busy",  busy, 0);
        check_eq("rst_done",  done, 0);
        check_eq("rst_valid", sccb_valid, 0);
        check_eq("rst_addr",  rom_addr, 0);
        check_eq("rst_reg",   sccb_reg, 0);
        check_eq("rst_data",  sccb_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic single write
        rom[0]   = 16'h1204;
        rom[1]   = 16'hFFFF;
        done_lat = 20;
        base     = n_xfer;
        pulse_start();
        check_eq("basic_busy", busy, 1);
        wait_done(300, "basic_done");
        check_eq("basic_count", n_xfer - base, 1);
        check_eq("basic_reg",   xfer_reg[base], 8'h12);
        check_eq("basic_data",  xfer_data[base], 8'h04);
        check_eq("basic_idle",  busy, 0);
        check_eq("basic_addr",  rom_addr, 1);

        // Delay sentinel: 100 cycles in DELAY, FETCH(1) -> FETCH(2) is 102 cycles
        rom_fill(16'hFFFF);
        rom[0]   = 16'h1280;
        rom[1]   = 16'hFFF0;
        rom[2]   = 16'h1180;
        rom[3]   = 16'hFFFF;
        done_lat = 5;
        base     = n_xfer;
        t1 = -1; t2 = -1; tv = -1; viol = 0;
        pulse_start();
        for (int i = 0; i < 500 && !done; i++) begin
            if (rom_addr == 8'd1 && t1 < 0) t1 = cyc;
            if (rom_addr == 8'd2 && t2 < 0) t2 = cyc;
            if (rom_addr == 8'd2 && sccb_valid && tv < 0) tv = cyc;
            if (t1 >= 0 && t2 < 0 && sccb_valid) viol++;
            @(negedge clk);
        end
        check_eq("delay_done",      done, 1);
        check_eq("delay_span",      t2 - t1, 102);
        check_eq("delay_valid_lat", tv - t2, 2);
        check_eq("delay_quiet",     viol, 0);
        check_eq("delay_count",     n_xfer - base, 2);
        check_eq("delay_reg2",      xfer_reg[base + 1], 8'h11);
        check_eq("delay_data2",     xfer_data[base + 1], 8'h80);

        // Backpressure: ready low for 7 cycles after valid rises
        rom_fill(16'hFFFF);
        rom[0]     = 16'h3355;
        sccb_ready = 1'b0;
        done_lat   = 3;
        base       = n_xfer;
        pulse_start();
        wait_valid(20, "bp_valid_rise");
        viol = 0;
        for (int i = 0; i < 7; i++) begin
            if (!sccb_valid || sccb_reg != 8'h33 || sccb_data != 8'h55) viol++;
            @(negedge clk);
        end
        check_eq("bp_hold",      viol, 0);
        check_eq("bp_no_xfer",   n_xfer - base, 0);
        check_eq("bp_valid_pre", sccb_valid, 1);
        sccb_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_valid_post", sccb_valid, 0);
        check_eq("bp_count",      n_xfer - base, 1);
        check_eq("bp_reg",        xfer_reg[base], 8'h33);
        wait_done(100, "bp_done");

        // Start while busy is ignored; restart replays the same list
        rom_fill(16'hFFFF);
        rom[0]   = 16'h2A01;
        rom[1]   = 16'h2B02;
        done_lat = 10;
        base     = n_xfer;
        pulse_start();
        for (int i = 0; i < 50 && n_xfer == base; i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_eq("sb_wait_busy", busy, 1);
        pulse_start();
        wait_done(300, "sb_done");
        check_eq("sb_count", n_xfer - base, 2);
        check_eq("sb_reg0",  xfer_reg[base], 8'h2A);
        check_eq("sb_data1", xfer_data[base + 1], 8'h02);
        base = n_xfer;
        pulse_start();
        check_eq("rs_done_clr", done, 0);
        check_eq("rs_busy",     busy, 1);
        check_eq("rs_addr",     rom_addr, 0);
        wait_done(300, "rs_done");
        check_eq("rs_count", n_xfer - base, 2);
        check_eq("rs_reg0",  xfer_reg[base], 8'h2A);
        check_eq("rs_data0", xfer_data[base], 8'h01);
        check_eq("rs_reg1",  xfer_reg[base + 1], 8'h2B);
        check_eq("rs_data1", xfer_data[base + 1], 8'h02);

        // Asynchronous reset during SEND
        rom_fill(16'hFFFF);
        rom[0]     = 16'h4455;
        sccb_ready = 1'b0;
        base       = n_xfer;
        pulse_start();
        wait_valid(20, "ar_in_send");
        #2 rst = 1'b1;
        #1;
        check_eq("ar_valid", sccb_valid, 0);
        check_eq("ar_busy",  busy, 0);
        check_eq("ar_done",  done, 0);
        check_eq("ar_addr",  rom_addr, 0);
        sccb_ready = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (sccb_valid || busy || done) viol++;
        end
        check_eq("ar_quiet", viol, 0);
        check_eq("ar_count", n_xfer - base, 0);

        // Full ROM with no end marker: 256 writes then done
        rom_fill(16'h0101);
        done_lat = 1;
        base     = n_xfer;
        pulse_start();
        wait_done(5000, "wrap_done");
        check_eq("wrap_count", n_xfer - base, 256);
        check_eq("wrap_addr",  rom_addr, 8'hFF);
        check_eq("wrap_idle",  busy, 0);
        repeat (20) @(negedge clk);
        check_eq("wrap_no_extra", n_xfer - base, 256);
        check_eq("wrap_valid",    sccb_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_cfg_sequencer.md
Name: cam_cfg_sequencer

Overview:
- Walks the camera configuration ROM from address 0 and issues each {register, value} pair as one SCCB write transaction to the SCCB master.
- Interprets two ROM sentinels: 16'hFF_F0 inserts a fixed delay; 16'hFF_FF ends the sequence.
- Sits between the top-level camera bring-up logic, the config ROM (1-cycle read latency) and the SCCB master.
- Signals completion so the capture pipeline can be enabled.

Parameters:
- CLK_FREQ, 25_000_000, i_clk frequency in Hz.
- DELAY_MS, 1, length of the FF_F0 delay in milliseconds.
- DELAY_CYCLES, CLK_FREQ/1000*DELAY_MS, derived local constant; not to be overridden.

Ports:
- i_clk, input, 1, system clock.
- i_rst, input, 1, asynchronous active-high reset.
- i_start, input, 1, single-cycle pulse that begins configuration.
- o_busy, output, 1, high from the accepted start until done.
- o_done, output, 1, level; high once the FF_FF marker is reached, cleared by the next accepted start.
- o_rom_addr, output, 8, config ROM address.
- i_rom_data, input, 16, ROM word, valid 1 cycle after o_rom_addr changes; [15:8] is the register, [7:0] is the value.
- o_sccb_valid, output, 1, write request to the SCCB master.
- o_sccb_reg, output, 8, register address for the write.
- o_sccb_data, output, 8, data byte for the write.
- i_sccb_ready, input, 1, SCCB master can accept a request.
- i_sccb_done, input, 1, single-cycle pulse when the SCCB write finishes on the bus.

Behaviour:
- Reset (async, i_rst=1) values:
  - State is IDLE.
  - o_rom_addr=0, o_busy=0, o_done=0, o_sccb_valid=0, o_sccb_reg=0, o_sccb_data=0.
  - Delay counter=0.
  - Reset asserted mid-transaction abandons everything immediately. No completion is awaited and no partial state is retained.
- State machine:
  - IDLE: on i_start go to FETCH; set o_rom_addr=0, o_busy=1, o_done=0.
  - FETCH: one-cycle wait to cover ROM latency; go to DECODE.
  - DECODE: examine i_rom_data.
    - FF_FF: go to DONE.
    - FF_F0: load the counter with DELAY_CYCLES-1 and go to DELAY.
    - Any other word: latch o_sccb_reg=i_rom_data[15:8] and o_sccb_data=i_rom_data[7:0], set o_sccb_valid=1, go to SEND.
  - SEND: hold valid, reg and data stable until a cycle with o_sccb_valid && i_sccb_ready.
    - That cycle is the transfer. Clear o_sccb_valid on the next edge and go to WAIT.
    - Valid must never drop before the transfer.
  - WAIT: on i_sccb_done, increment o_rom_addr and go to FETCH.
  - DELAY: decrement the counter each cycle. At 0, increment o_rom_addr and go to FETCH.
    - The delay lasts exactly DELAY_CYCLES cycles in DELAY.
  - DONE: o_busy=0, o_done=1; go to IDLE on the same edge.
    - o_done stays 1 in IDLE until the next accepted i_start.
- Start handling: i_start is ignored unless in IDLE. It is not queued.
- Address wrap: if the increment would take o_rom_addr from 255 to 0, go to DONE instead of FETCH. A maximum of 256 entries is processed.
- Spurious i_sccb_done outside WAIT is ignored.
- i_sccb_done arriving in the same cycle as the SEND transfer (a zero-latency master) is not allowed. The bench must not generate it.
- Throughput: a normal entry takes FETCH + DECODE + SEND (at least 1 cycle) + WAIT. The minimum is 4 cycles plus bus time.
- Widths:
  - Delay counter is $clog2(DELAY_CYCLES+1) bits.
  - All arithmetic is unsigned, with no truncation of DELAY_CYCLES.

Decomposition:
- Shared package cam_cfg_pkg:
  - State enum (IDLE, FETCH, DECODE, SEND, WAIT, DELAY, DONE).
  - Sentinel constants CFG_DELAY=16'hFF_F0 and CFG_END=16'hFF_FF.
  - ROM address width constant (8).
- One sub-module, cfg_delay_timer: loadable down-counter with a terminal-count flag, parameterised by width.
  - The ROM and the SCCB master remain separate instances at the parent level.

Test Plan:
- Basic write:
  - ROM {0:16'h12_04, 1:16'hFF_FF}, ready=1, done pulse 20 cycles after the transfer.
  - Required: exactly one transfer with reg=8'h12, data=8'h04; o_done=1 and o_busy=0 after address 1; o_rom_addr is 1 at done.
- Delay handling:
  - CLK_FREQ=100_000, DELAY_MS=1 (100 cycles); ROM {0:12_80, 1:FF_F0, 2:11_80, 3:FF_FF}.
  - Required: no SCCB request during the 100 DELAY cycles; the second transfer starts exactly 102 cycles after FETCH of address 1; two transfers total.
- Backpressure:
  - i_sccb_ready held low 7 cycles after valid rises.
  - Required: o_sccb_valid stays 1 with reg/data constant for all 7 cycles; transfer on the first ready=1 cycle; valid=0 on the next cycle.
- Start while busy and restart:
  - Pulse i_start during WAIT: no effect, transaction count unchanged.
  - Pulse i_start after done: o_done drops next cycle and the sequence replays from address 0 with the identical transaction list.
- Reset mid-operation:
  - Assert i_rst asynchronously (between edges) during SEND.
  - Required: o_sccb_valid=0, o_busy=0, o_done=0, o_rom_addr=0 immediately; after release, nothing happens until i_start.
- Full-ROM wrap:
  - ROM returns 16'h01_01 for all 256 addresses (no FF_FF).
  - Required: 256 transfers, then o_done=1; no 257th request.
